// File: rtl/wide_add_seq_pkg.sv
// wide_add_seq_pkg: shared FSM state type and default geometry for wide_add_seq
package wide_add_seq_pkg;
  localparam int SLICE_W_DEF    = 16;
  localparam int NUM_SLICES_DEF = 4;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
endpackage

// File: rtl/wide_add_seq.sv
// wide_add_seq: serial wide adder driving an external slice adder; WIDE_ADD_SEQ_SUB_EN adds a sub input for subtraction
module wide_add_seq
  import wide_add_seq_pkg::*;
#(
  parameter int SLICE_W    = SLICE_W_DEF,
  parameter int NUM_SLICES = NUM_SLICES_DEF,
  localparam int W  = SLICE_W * NUM_SLICES,
  localparam int IW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [W-1:0]       op_a,
  input  logic [W-1:0]       op_b,
  input  logic               cin,
`ifdef WIDE_ADD_SEQ_SUB_EN
  input  logic               sub,
`endif
  output logic               busy,
  output logic               done,
  output logic [W-1:0]       sum,
  output logic               cout,
  output logic               add_en,
  output logic [SLICE_W-1:0] add_a,
  output logic [SLICE_W-1:0] add_b,
  output logic               add_cin,
  input  logic               add_vail,
  input  logic [SLICE_W-1:0] add_result,
  input  logic               add_cout
);
  state_t         state;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  nxt;
  logic           carry;
  logic [W-1:0]   b_in;
  logic           c_in;
  logic           last;
  // Subtraction is folded into operand B and the initial carry at start time
`ifdef WIDE_ADD_SEQ_SUB_EN
  assign b_in = sub ? ~op_b : op_b;
  assign c_in = sub | cin;
`else
  assign b_in = op_b;
  assign c_in = cin;
`endif
  assign nxt  = idx + 1'b1;
  assign last = idx == IW'(NUM_SLICES - 1);
  // Sequencer: one slice at a time, next slice issued only after the previous result returns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx     <= '0;
      carry   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      add_en  <= 1'b0;
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= op_a;
            b_q     <= b_in;
            carry   <= c_in;
            idx     <= '0;
            busy    <= 1'b1;
            add_en  <= 1'b1;
            add_a   <= op_a[SLICE_W-1:0];
            add_b   <= b_in[SLICE_W-1:0];
            add_cin <= c_in;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          add_en  <= 1'b0;
          add_a   <= '0;
          add_b   <= '0;
          add_cin <= 1'b0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (add_vail) begin
            sum[idx*SLICE_W +: SLICE_W] <= add_result;
            carry <= add_cout;
            if (last) begin
              state <= S_DONE;
            end else begin
              idx     <= nxt;
              add_en  <= 1'b1;
              add_a   <= a_q[nxt*SLICE_W +: SLICE_W];
              add_b   <= b_q[nxt*SLICE_W +: SLICE_W];
              add_cin <= add_cout;
              state   <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          cout  <= carry;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wide_add_seq.sv
// tb_wide_add_seq: scoreboard bench for wide_add_seq with a registered slice-adder model
module tb_wide_add_seq;
  localparam int SW = 16;
  localparam int NS = 4;
  localparam int W  = SW * NS;
  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           lat;
    int           t0;
  } exp_t;
  logic          clk = 0;
  logic          rst_n = 0;
  logic          start = 0;
  logic          cin = 0;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
`ifdef WIDE_ADD_SEQ_SUB_EN
  logic          sub = 0;
`endif
  logic          busy, done, cout, add_en, add_cin;
  logic [W-1:0]  sum;
  logic [SW-1:0] add_a, add_b;
  logic          add_vail = 0;
  logic          add_cout = 0;
  logic [SW-1:0] add_result = '0;
  exp_t          q[$];
  exp_t          e;
  int            checks = 0, errors = 0, cyc = 0, dly_slice = -1, slc = 0, cnt = 0;
  int            en_hi = 0, en_pulses = 0, t;
  logic          en_d = 0;

  wide_add_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef WIDE_ADD_SEQ_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .add_en(add_en), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_vail(add_vail), .add_result(add_result), .add_cout(add_cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, got, exp);
    end
  endtask

  // Registered slice adder; the slice numbered dly_slice answers two cycles later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_vail <= 0;
      cnt      <= 0;
      slc      <= 0;
    end else begin
      add_vail <= 0;
      if (cnt == 1) add_vail <= 1;
      if (cnt > 0) cnt <= cnt - 1;
      if (add_en) begin
        {add_cout, add_result} <= {1'b0, add_a} + {1'b0, add_b} + {{SW{1'b0}}, add_cin};
        if (slc == dly_slice) cnt <= 2;
        else add_vail <= 1;
        slc <= (slc == NS - 1) ? 0 : slc + 1;
      end
    end
  end

  // Monitor: checks idle slice bus, counts add_en pulses, pops scoreboard on done
  always @(negedge clk) begin
    if (!rst_n) begin
      en_d = 0;
      en_hi = 0;
      en_pulses = 0;
    end else begin
      if (add_en && !en_d) en_pulses++;
      if (add_en) en_hi++;
      en_d = add_en;
      if (!add_en) chk("idle_slice_bus", W'({add_a, add_b, add_cin}), '0);
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got sum %h expected no done", sum);
        end else begin
          e = q.pop_front();
          chk("sum", sum, e.s);
          chk("cout", W'(cout), W'(e.c));
          chk("latency", W'(cyc - e.t0), W'(e.lat));
          chk("add_en_pulses", W'(en_pulses), W'(NS));
          chk("add_en_high_cycles", W'(en_hi), W'(NS));
          chk("busy_at_done", W'(busy), '0);
        end
        en_hi = 0;
        en_pulses = 0;
      end
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, output int t0);
    op_a = a;
    op_b = b;
    cin = c;
    start = 1;
    t0 = cyc + 1;
    @(negedge clk);
    start = 0;
    op_a = '0;
    op_b = '0;
    cin = 0;
    chk("busy_after_start", W'(busy), W'(1));
  endtask

  task automatic push(input logic [W-1:0] s, input logic c, input int lat, input int t0);
    exp_t x;
    x.s = s;
    x.c = c;
    x.lat = lat;
    x.t0 = t0;
    q.push_back(x);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got %0d pending expected 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                     input logic [W-1:0] s, input logic co, input int lat);
    int t0;
    start_op(a, b, c, t0);
    push(s, co, lat, t0);
    drain();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", W'(busy), '0);
    chk("reset_done", W'(done), '0);
    chk("reset_add_en", W'(add_en), '0);
    chk("reset_sum", sum, '0);
    chk("reset_cout", W'(cout), '0);
    rst_n = 1;
    @(negedge clk);
    run(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 64'h0, 1, 9);
    run(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1, 64'h0011_0022_0033_0045, 0, 9);
    start_op(64'h1234, 64'h1, 0, t);
    push(64'h1235, 0, 9, t);
    repeat (2) @(negedge clk);
    start_op(64'hAAAA_AAAA, 64'h5555_5555, 1, e.t0);
    drain();
    chk("sum_held", sum, 64'h1235);
    start_op(64'h1111_2222_3333_4444, 64'h1, 0, t);
    while (cyc < t + 5) @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_busy", W'(busy), '0);
    chk("abort_done", W'(done), '0);
    chk("abort_add_en", W'(add_en), '0);
    chk("abort_sum", sum, '0);
    chk("abort_cout", W'(cout), '0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run(64'd5, 64'd7, 0, 64'd12, 0, 9);
    dly_slice = 1;
    run(64'h0000_8000_FFFF_FFFF, 64'h0000_8000_0000_0001, 0, 64'h0001_0001_0000_0000, 0, 11);
    dly_slice = -1;
    run(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 9);
`ifdef WIDE_ADD_SEQ_SUB_EN
    sub = 1;
    run(64'd5, 64'd7, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 9);
    run(64'd7, 64'd5, 0, 64'd2, 1, 9);
    sub = 0;
`endif
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", W'(q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
